// File: rtl/apb_mem_pkg.sv
// ============================================================================
// apb_mem_pkg : shared FSM type, width helpers and address decode check.
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_mem_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_width(input int mem_depth);
    return (mem_depth > 1) ? $clog2(mem_depth) : 1;
  endfunction

  // Flags misaligned, below-base and beyond-depth byte addresses.
  function automatic logic mem_addr_err(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input int          shift,
                                        input logic [63:0] depth);
    logic [63:0] off;
    logic [63:0] mask;
    logic [63:0] idx;
    off  = addr - base;
    mask = (64'd1 << shift) - 64'd1;
    idx  = off >> shift;
    return ((off & mask) != 64'd0) || (addr < base) || (idx >= depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_mem_array.sv
// ============================================================================
// apb_mem_array : single-port memory, per-byte write enable, registered read.
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [idx_width(MEM_DEPTH)-1:0]  i_addr,
  input  logic [DATA_WIDTH/8-1:0]          i_wstrb,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic                             i_rd_en,
  input  logic                             i_rd_clr,
  output logic [DATA_WIDTH-1:0]            o_rdata
);

  localparam int STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge PCLK) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (i_wstrb[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Read port holds its last value; only the output register is reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      o_rdata <= '0;
    end else if (i_rd_en) begin
      o_rdata <= i_rd_clr ? '0 : r_mem[i_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_mem_slave.sv
// ============================================================================
// apb_mem_slave : APB4 slave backed by a byte-writable scratchpad memory.
// Option APB_MEM_SLAVE_PPROT_EN adds PPROT write protection of the upper half.
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          MEM_DEPTH   = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'd0,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`ifdef APB_MEM_SLAVE_PPROT_EN
  input  logic [2:0]              PPROT,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int STRB_W     = strb_width(DATA_WIDTH);
  localparam int BYTE_SHIFT = byte_shift(DATA_WIDTH);
  localparam int IDX_W      = idx_width(MEM_DEPTH);

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic                  r_err;
  logic [IDX_W-1:0]      r_idx;

  logic                  w_setup;
  logic [63:0]           w_off;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_addr_err;
  logic                  w_priv_err;
  logic                  w_setup_err;
  logic [IDX_W-1:0]      w_mem_addr;
  logic [STRB_W-1:0]     w_mem_strb;
  logic                  w_rd_en;

  assign w_setup     = PSEL && !PENABLE;
  assign w_off       = 64'(PADDR) - BASE_ADDR;
  assign w_idx       = w_off[BYTE_SHIFT +: IDX_W];
  assign w_addr_err  = mem_addr_err(64'(PADDR), BASE_ADDR, BYTE_SHIFT, 64'(MEM_DEPTH));
  assign w_setup_err = w_addr_err || w_priv_err;

`ifdef APB_MEM_SLAVE_PPROT_EN
  logic w_unused_prot;
  // Unprivileged writes may not touch the upper half of the array.
  assign w_priv_err    = PWRITE && !PPROT[0] && (32'(w_idx) >= 32'(MEM_DEPTH / 2));
  assign w_unused_prot = ^PPROT[2:1];
`else
  assign w_priv_err    = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_setup) begin
        r_write <= PWRITE;
        r_err   <= w_setup_err;
        r_idx   <= w_idx;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == ACCESS && PSEL && PENABLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_setup) w_next_state = ACCESS;
      ACCESS:  if (!PSEL || r_cnt == 4'd0) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Memory address comes from the live bus during setup, latched index otherwise.
  always_comb begin
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;
    w_mem_strb = '0;
    w_rd_en    = 1'b0;
    w_mem_addr = r_idx;
    case (r_state)
      IDLE: begin
        w_mem_addr = w_idx;
        w_rd_en    = w_setup && !PWRITE;
      end
      ACCESS: begin
        PREADY  = PSEL && (r_cnt == 4'd0);
        PSLVERR = PREADY && r_err;
        if (PREADY && r_write && !r_err) begin
          w_mem_strb = PSTRB;
        end
      end
      default: ;
    endcase
  end

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .i_addr   (w_mem_addr),
    .i_wstrb  (w_mem_strb),
    .i_wdata  (PWDATA),
    .i_rd_en  (w_rd_en),
    .i_rd_clr (w_setup_err),
    .o_rdata  (PRDATA)
  );

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
// ============================================================================
// tb_apb_mem_slave : directed bench for apb_mem_slave, WAIT_CYCLES 0 and 3.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_apb_mem_slave;

  localparam int DEPTH = 1024;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pstrb [2];
  logic [2:0]  pprot [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];

  logic        exp_ready [2];
  logic        exp_err [2];
  logic [31:0] exp_rdata [2];
  logic [31:0] mdl [2][DEPTH];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    apb_mem_slave #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .MEM_DEPTH   (DEPTH),
      .BASE_ADDR   (64'd0),
      .WAIT_CYCLES (g * 3)
    ) u_dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .PSEL    (psel[g]),
      .PENABLE (penable[g]),
      .PWRITE  (pwrite[g]),
      .PADDR   (paddr[g]),
      .PWDATA  (pwdata[g]),
      .PSTRB   (pstrb[g]),
`ifdef APB_MEM_SLAVE_PPROT_EN
      .PPROT   (pprot[g]),
`endif
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g])
    );
  end

  function automatic int wait_of(input int d);
    return d * 3;
  endfunction

  function automatic bit model_err(input bit wr, input logic [31:0] addr, input logic [2:0] prot);
    bit e;
    e = (addr % 4 != 0) || (addr / 4 >= DEPTH);
`ifdef APB_MEM_SLAVE_PPROT_EN
    if (wr && !prot[0] && addr / 4 >= DEPTH / 2) e = 1'b1;
`else
    if (wr && prot == 3'b111 && 1'b0) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESETn) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pready%0d", d),  32'(pready[d]),  32'(exp_ready[d]));
        chk($sformatf("pslverr%0d", d), 32'(pslverr[d]), 32'(exp_err[d]));
        chk($sformatf("prdata%0d", d),  prdata[d],       exp_rdata[d]);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after completion or abort.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [2:0] prot, input int abort_at);
    bit err;
    int idx;
    err = model_err(wr, addr, prot);
    idx = int'(addr >> 2);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
    pwdata[d] = data; pstrb[d] = strb; pprot[d] = prot;
    exp_ready[d] = 1'b0; exp_err[d] = 1'b0;
    @(posedge PCLK); #1;
    penable[d] = 1'b1;
    if (!wr) begin
      if (err) exp_rdata[d] = 32'h0;
      else     exp_rdata[d] = mdl[d][idx];
    end
    for (int k = 0; k <= wait_of(d); k++) begin
      if (k == abort_at) begin
        psel[d] = 1'b0; penable[d] = 1'b0;
        exp_ready[d] = 1'b0; exp_err[d] = 1'b0;
        @(posedge PCLK); #1;
        return;
      end
      exp_ready[d] = (k == wait_of(d));
      exp_err[d]   = exp_ready[d] && err;
      @(posedge PCLK); #1;
    end
    if (wr && !err) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) mdl[d][idx][8*i +: 8] = data[8*i +: 8];
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
    exp_ready[d] = 1'b0; exp_err[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    xfer(d, 1'b1, addr, data, strb, 3'b000, -1);
  endtask

  task automatic rd(input int d, input logic [31:0] addr);
    xfer(d, 1'b0, addr, 32'h0, 4'h0, 3'b000, -1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = 32'h0;
      pwdata[d] = 32'h0; pstrb[d] = 4'h0; pprot[d] = 3'b000;
      exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_rdata[d] = 32'h0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_prdata", prdata[d], 32'h0);
      chk("rst_pready", 32'(pready[d]), 32'h0);
      chk("rst_pslverr", 32'(pslverr[d]), 32'h0);
    end
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
    rd(0, 32'h10);
    chk("rd_10", prdata[0], 32'hDEADBEEF);

    wr(0, 32'h20, 32'h11223344, 4'hF);
    wr(0, 32'h20, 32'hAABBCCDD, 4'b0101);
    rd(0, 32'h20);
    chk("rd_strb", prdata[0], 32'h11BB33DD);

    @(posedge PCLK); #1;
    wr(0, 32'h0, 32'h0BADF00D, 4'hF);
    wr(0, 32'h1000, 32'hFFFFFFFF, 4'hF);
    rd(0, 32'h1000);
    chk("rd_oob", prdata[0], 32'h0);
    rd(0, 32'h0);
    chk("rd_alias", prdata[0], 32'h0BADF00D);
    wr(0, 32'h13, 32'h12345678, 4'hF);
    rd(0, 32'h13);
    chk("rd_misal", prdata[0], 32'h0);
    rd(0, 32'h10);
    chk("rd_after_misal", prdata[0], 32'hDEADBEEF);
    wr(0, 32'h10, 32'h00000000, 4'h0);
    rd(0, 32'h10);
    chk("rd_strb0", prdata[0], 32'hDEADBEEF);

    // Access phase without a setup must be ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h10;
    pwdata[0] = 32'h0; pstrb[0] = 4'hF;
    repeat (2) begin @(posedge PCLK); #1; end
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge PCLK); #1;
    rd(0, 32'h10);
    chk("rd_nosetup", prdata[0], 32'hDEADBEEF);

    wr(1, 32'h40, 32'h55AA1234, 4'hF);
    rd(1, 32'h40);
    chk("w3_rd", prdata[1], 32'h55AA1234);
    xfer(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 3'b000, 1);
    rd(1, 32'h40);
    chk("w3_abort", prdata[1], 32'h55AA1234);
    rd(1, 32'h13);
    chk("w3_err", prdata[1], 32'h0);

`ifdef APB_MEM_SLAVE_PPROT_EN
    xfer(0, 1'b1, 32'h960, 32'h12345678, 4'hF, 3'b001, -1);
    xfer(0, 1'b1, 32'h960, 32'hCAFEF00D, 4'hF, 3'b000, -1);
    rd(0, 32'h960);
    chk("prot_blocked", prdata[0], 32'h12345678);
    xfer(0, 1'b1, 32'h960, 32'h9ABCDEF0, 4'hF, 3'b001, -1);
    rd(0, 32'h960);
    chk("prot_priv", prdata[0], 32'h9ABCDEF0);
    xfer(0, 1'b1, 32'h28, 32'h0F0F0F0F, 4'hF, 3'b000, -1);
    rd(0, 32'h28);
    chk("prot_low", prdata[0], 32'h0F0F0F0F);
`endif

    // Reset while a WAIT_CYCLES=3 read is in its access phase.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h40;
    @(posedge PCLK); #1;
    penable[1] = 1'b1;
    exp_rdata[1] = mdl[1][16];
    #2;
    chk("mid_prdata", prdata[1], 32'h55AA1234);
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_pready", 32'(pready[1]), 32'h0);
    chk("rst_mid_pslverr", 32'(pslverr[1]), 32'h0);
    chk("rst_mid_prdata1", prdata[1], 32'h0);
    chk("rst_mid_prdata0", prdata[0], 32'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
    #3;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    rd(1, 32'h40);
    chk("rd_after_rst", prdata[1], 32'h55AA1234);

    @(posedge PCLK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB4 slave backed by an internal byte-writable memory, used as a scratchpad and APB verification target.
- Generalises width, depth and base address.
- Adds byte strobes, programmable wait states, an explicit IDLE/ACCESS FSM, and PSLVERR on out-of-range or misaligned accesses.
- Sits on the APB bus as a single slave behind the bridge decoder.

Parameters:
- DATA_WIDTH, 32, bus and word width; legal values 8/16/32/64.
- ADDR_WIDTH, 32, PADDR width.
- MEM_DEPTH, 1024, number of DATA_WIDTH words.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_WIDTH/8.
- WAIT_CYCLES, 0, wait states inserted in every access phase (0..15).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte-lane enables.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response, qualified by PREADY.

Behaviour:
- Reset: PRESETn, asynchronous, active-low; clock PCLK. Reset forces state IDLE, PRDATA=0, PREADY=0, PSLVERR=0 and wait counter=0. Memory array is not reset.
- Address decode:
  - off = PADDR - BASE_ADDR; idx = off >> log2(DATA_WIDTH/8).
  - err = (off low bits != 0) OR (PADDR < BASE_ADDR) OR (idx >= MEM_DEPTH).
- FSM, IDLE state:
  - Setup phase detected when PSEL=1 & PENABLE=0.
  - On setup: latch PWRITE, idx, err; load cnt=WAIT_CYCLES; go to ACCESS.
  - On a read setup, also register PRDATA <= err ? 0 : mem[idx] at the same edge.
  - PSEL=1 & PENABLE=1 without a preceding setup is ignored: stay IDLE, PREADY=0.
- FSM, ACCESS state:
  - PREADY = (cnt==0), combinational from state and counter.
  - While PSEL=1 & PENABLE=1 and cnt!=0: decrement cnt.
  - Completion cycle (PREADY=1): PSLVERR = latched err. If write & !err, memory update at this edge: byte i written iff PSTRB[i]. Next state IDLE.
  - PSEL=0 in ACCESS (master abort): return to IDLE, no memory update, PREADY/PSLVERR stay 0.
- Latency:
  - WAIT_CYCLES=0 gives a 2-cycle transfer (setup + access).
  - WAIT_CYCLES=N gives 2+N cycles.
  - Back-to-back transfers: the next setup may follow a completion immediately; IDLE accepts it in the following cycle.
- Error rules:
  - Erroring write: memory unchanged.
  - Erroring read: PRDATA=0.
  - PSTRB is ignored on reads. PSTRB=0 on a write is legal: no bytes change, no error.
- Output hold: PRDATA holds its value outside read completions; it is not cleared.
- Reset mid-transfer: immediate IDLE, outputs 0; any pending write is dropped.

Optional Feature:
- Macro APB_MEM_SLAVE_PPROT_EN.
- Defined:
  - Adds input PPROT [2:0], latched at setup.
  - A write with PPROT[0]=0 (unprivileged) to the upper half of the array (idx >= MEM_DEPTH/2) completes with PSLVERR=1 and no memory update.
  - Reads are unaffected.
- Undefined: no PPROT port; all in-range aligned accesses succeed.

Decomposition:
- Package apb_mem_pkg:
  - state enum {IDLE, ACCESS}.
  - Constants STRB_W = DATA_WIDTH/8 and BYTE_SHIFT = $clog2(STRB_W).
  - Function for the decode/error check.
- Sub-module apb_mem_array:
  - Single-port synchronous memory with per-byte write enable and registered read; parametrised by DATA_WIDTH and MEM_DEPTH.
  - The FSM, wait counter and decode stay in apb_mem_slave.

Test Plan:
- Reset then idle: PRDATA=0, PREADY=0, PSLVERR=0; reset asserted mid-ACCESS returns all outputs to 0 in the same cycle.
- Write 0xDEADBEEF to 0x10 with PSTRB=4'hF, then read 0x10: PRDATA=0xDEADBEEF, PSLVERR=0; with WAIT_CYCLES=0, PREADY is high in the 2nd cycle of each transfer.
- Write 0x11223344 to 0x20 with PSTRB=4'hF, then write 0xAABBCCDD with PSTRB=4'b0101, then read: 0x11BB33DD.
- Access 0x1000 with MEM_DEPTH=1024, then access 0x13 (misaligned): PREADY=1 with PSLVERR=1; a read returns 0; re-reading the prior contents shows memory unchanged.
- WAIT_CYCLES=3: PREADY stays low for 3 access cycles and is high on the 4th; PSEL dropped after 1 access cycle aborts the transfer with no write.
- With APB_MEM_SLAVE_PPROT_EN: write to idx 600 with PPROT=3'b000 gives PSLVERR=1 and data unchanged; PPROT=3'b001 succeeds; write to idx 10 with PPROT=3'b000 succeeds.
